apb_master_arbiter: RTL and testbench

- Single APB master sequencer sitting in front of the six-port APB interconnect.
- Arbitrates between two requesters, port 0 (core LSU) and port 1 (debug/DMA), round-robin.
- Drives the IDLE/SETUP/ACCESS protocol (psel, penable, address, write, wdata) into the interconnect.
- Returns prdata and pslverr to the winning requester. Enforces a PREADY timeout and rejects unmapped slots without starting an APB transfer.

---
 rtl/apb_pkg.sv | 25 ++
 rtl/apb_rr_arbiter.sv | 33 +++
 rtl/apb_master_arbiter.sv | 152 +++++++++++++++
 tb/tb_apb_master_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and slot map for the APB master sequencer and its arbiter.
// Slot decode uses address bits [15:13]; slots 0 and 7 are unmapped.
package apb_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    localparam logic [2:0] SLOT_TIMER = 3'd1;
    localparam logic [2:0] SLOT_PWM   = 3'd2;
    localparam logic [2:0] SLOT_UART  = 3'd3;
    localparam logic [2:0] SLOT_GPIO  = 3'd4;
    localparam logic [2:0] SLOT_SPI   = 3'd5;
    localparam logic [2:0] SLOT_I2C   = 3'd6;

    function automatic logic is_mapped_slot(input logic [2:0] slot);
        return (slot >= SLOT_TIMER) && (slot <= SLOT_I2C);
    endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin arbiter. On a tie the port that did not win last time
// is granted; last_grant resets to 1 so port 0 wins the first tie.
module apb_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_grant;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (advance && (req != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master sequencer: arbitrates two requesters, runs IDLE/SETUP/ACCESS,
// enforces a PREADY timeout and rejects unmapped slots without a bus cycle.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic              req0_we,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic              req1_we,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    output logic              psel,
    output logic              penable,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic              owner_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        grant;
    logic              accept;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic [DATA_W-1:0] sel_wdata;
    logic              mapped;
    logic              timeout_hit;
    logic              rsp_fire;
    logic              rsp_port_d;
    logic              rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_d;

    assign accept = (state_q == IDLE) && (req0_valid || req1_valid);

    apb_rr_arbiter u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({req1_valid, req0_valid}),
        .advance (accept),
        .grant   (grant)
    );

    assign req0_ready  = accept && grant[0];
    assign req1_ready  = accept && grant[1];
    assign sel_addr    = grant[1] ? req1_addr  : req0_addr;
    assign sel_we      = grant[1] ? req1_we    : req0_we;
    assign sel_wdata   = grant[1] ? req1_wdata : req0_wdata;
    assign mapped      = is_mapped_slot(sel_addr[15:13]);
    // cnt_q counts earlier wait cycles, so this is the TIMEOUT-th ACCESS cycle.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    assign psel    = (state_q != IDLE);
    assign penable = (state_q == ACCESS);

    always_comb begin
        state_d     = state_q;
        rsp_fire    = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        rsp_port_d  = owner_q;
        unique case (state_q)
            IDLE: begin
                rsp_port_d = grant[1];
                if (accept) begin
                    if (mapped) begin
                        state_d = SETUP;
                    end else begin
                        rsp_fire  = 1'b1;
                        rsp_err_d = 1'b1;
                    end
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (pready) begin
                    state_d     = IDLE;
                    rsp_fire    = 1'b1;
                    rsp_err_d   = pslverr;
                    rsp_rdata_d = pwrite ? '0 : prdata;
                end else if (timeout_hit) begin
                    state_d   = IDLE;
                    rsp_fire  = 1'b1;
                    rsp_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            cnt_q      <= '0;
            paddr      <= '0;
            pwrite     <= 1'b0;
            pwdata     <= '0;
            rsp0_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_rdata <= '0;
            rsp1_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q <= grant[1];
                paddr   <= sel_addr;
                pwrite  <= sel_we;
                pwdata  <= sel_wdata;
            end
            if (state_d == SETUP) begin
                cnt_q <= '0;
            end else if ((state_q == ACCESS) && !pready && !timeout_hit) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            rsp0_valid <= rsp_fire && !rsp_port_d;
            rsp1_valid <= rsp_fire && rsp_port_d;
            if (rsp_fire && !rsp_port_d) begin
                rsp0_rdata <= rsp_rdata_d;
                rsp0_err   <= rsp_err_d;
            end
            if (rsp_fire && rsp_port_d) begin
                rsp1_rdata <= rsp_rdata_d;
                rsp1_err   <= rsp_err_d;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: transaction-level model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_apb_master_arbiter;

    localparam int ADDR_W  = 20;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req0_ready, req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              rsp0_valid, rsp0_err;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              req1_valid, req1_ready, req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp1_valid, rsp1_err;
    logic [DATA_W-1:0] rsp1_rdata;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite, psel, penable, pready, pslverr;
    logic [DATA_W-1:0] pwdata, prdata;

    always #5 clk = ~clk;

    apb_master_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_we    (req0_we),
        .req0_wdata (req0_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp0_err   (rsp0_err),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_we    (req1_we),
        .req1_wdata (req1_wdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .rsp1_err   (rsp1_err),
        .paddr      (paddr),
        .pwrite     (pwrite),
        .pwdata     (pwdata),
        .psel       (psel),
        .penable    (penable),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: m_age counts cycles since accept (1 = setup, >=2 = access).
    bit              m_init = 1'b0;
    bit              m_busy = 1'b0;
    bit              m_owner;
    int              m_age;
    logic [ADDR_W-1:0] m_addr;
    bit              m_we;
    logic [DATA_W-1:0] m_wdata;
    bit              m_last = 1'b1;
    bit              m_rsp_v = 1'b0;
    bit              m_rsp_port;
    logic [DATA_W-1:0] m_rsp_data;
    bit              m_rsp_err;

    always @(negedge clk) begin
        logic [1:0] rq;
        bit         g_valid;
        bit         g_port;
        logic [2:0] slot;
        rq      = {req1_valid, req0_valid};
        g_valid = !m_busy && (rq != 2'b00);
        g_port  = (rq == 2'b11) ? !m_last : rq[1];
        if (m_init) begin
            check("req0_ready", req0_ready, g_valid && !g_port);
            check("req1_ready", req1_ready, g_valid && g_port);
            check("psel", psel, m_busy);
            check("penable", penable, m_busy && (m_age >= 2));
            if (m_busy) begin
                check("paddr", paddr, m_addr);
                check("pwrite", pwrite, m_we);
                check("pwdata", pwdata, m_wdata);
            end
            check("rsp0_valid", rsp0_valid, m_rsp_v && !m_rsp_port);
            check("rsp1_valid", rsp1_valid, m_rsp_v && m_rsp_port);
            if (m_rsp_v && !m_rsp_port) begin
                check("rsp0_rdata", rsp0_rdata, m_rsp_data);
                check("rsp0_err", rsp0_err, m_rsp_err);
            end
            if (m_rsp_v && m_rsp_port) begin
                check("rsp1_rdata", rsp1_rdata, m_rsp_data);
                check("rsp1_err", rsp1_err, m_rsp_err);
            end
        end
        if (rst) begin
            m_init  = 1'b1;
            m_busy  = 1'b0;
            m_age   = 0;
            m_last  = 1'b1;
            m_rsp_v = 1'b0;
        end else if (m_init) begin
            m_rsp_v = 1'b0;
            if (g_valid) begin
                m_last  = g_port;
                m_owner = g_port;
                m_addr  = g_port ? req1_addr  : req0_addr;
                m_we    = g_port ? req1_we    : req0_we;
                m_wdata = g_port ? req1_wdata : req0_wdata;
                slot    = m_addr[15:13];
                if (slot != 3'd0 && slot != 3'd7) begin
                    m_busy = 1'b1;
                    m_age  = 1;
                end else begin
                    m_rsp_v    = 1'b1;
                    m_rsp_port = g_port;
                    m_rsp_data = '0;
                    m_rsp_err  = 1'b1;
                end
            end else if (m_busy) begin
                if (m_age == 1) begin
                    m_age = 2;
                end else if (pready) begin
                    m_busy     = 1'b0;
                    m_rsp_v    = 1'b1;
                    m_rsp_port = m_owner;
                    m_rsp_data = m_we ? '0 : prdata;
                    m_rsp_err  = pslverr;
                end else if (m_age - 1 == TIMEOUT) begin
                    m_busy     = 1'b0;
                    m_rsp_v    = 1'b1;
                    m_rsp_port = m_owner;
                    m_rsp_data = '0;
                    m_rsp_err  = 1'b1;
                end else begin
                    m_age++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_addr = '0; req0_we = 1'b0; req0_wdata = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_we = 1'b0; req1_wdata = '0;
        pready = 1'b1; prdata = '0; pslverr = 1'b0;
        step();
        step();
        @(negedge clk);
        check("rst_psel", psel, 1'b0);
        check("rst_penable", penable, 1'b0);
        check("rst_paddr", paddr, 20'h0);
        check("rst_pwdata", pwdata, 32'h0);
        check("rst_pwrite", pwrite, 1'b0);
        check("rst_rsp0_valid", rsp0_valid, 1'b0);
        check("rst_rsp1_valid", rsp1_valid, 1'b0);
        check("rst_rsp0_rdata", rsp0_rdata, 32'h0);
        check("rst_rsp1_err", rsp1_err, 1'b0);
        step();
        rst = 1'b0;
        step();

        // Port 0 read, zero-wait slave
        req0_valid = 1'b1; req0_addr = 20'h06004; req0_we = 1'b0;
        prdata = 32'hDEADBEEF; pready = 1'b1;
        @(negedge clk); check("t1_ready0", req0_ready, 1'b1);
        step(); req0_valid = 1'b0;
        @(negedge clk); check("t1_setup_psel", psel, 1'b1); check("t1_setup_penable", penable, 1'b0);
        check("t1_setup_paddr", paddr, 20'h06004);
        step();
        @(negedge clk); check("t1_access_penable", penable, 1'b1);
        step();
        @(negedge clk);
        check("t1_rsp0_valid", rsp0_valid, 1'b1);
        check("t1_rsp0_rdata", rsp0_rdata, 32'hDEADBEEF);
        check("t1_rsp0_err", rsp0_err, 1'b0);
        check("t1_idle_psel", psel, 1'b0);
        step();

        // Port 1 write, 3 wait states, slave error
        req1_valid = 1'b1; req1_addr = 20'h08010; req1_we = 1'b1; req1_wdata = 32'h5A5A5A5A;
        pready = 1'b0; pslverr = 1'b1; prdata = 32'h12345678;
        @(negedge clk); check("t2_ready1", req1_ready, 1'b1);
        step(); req1_valid = 1'b0; req1_addr = '0; req1_wdata = '0;
        @(negedge clk); check("t2_setup_psel", psel, 1'b1);
        step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_penable_held", penable, 1'b1);
            check("t2_paddr_stable", paddr, 20'h08010);
            check("t2_pwdata_stable", pwdata, 32'h5A5A5A5A);
            step();
            if (i == 2) pready = 1'b1;
        end
        @(negedge clk);
        check("t2_rsp1_valid", rsp1_valid, 1'b1);
        check("t2_rsp1_err", rsp1_err, 1'b1);
        check("t2_rsp1_rdata", rsp1_rdata, 32'h0);
        check("t2_rsp0_quiet", rsp0_valid, 1'b0);
        step(); pslverr = 1'b0;

        // Continuous dual requests: grants alternate 0,1,0,1 every 3 cycles
        req0_valid = 1'b1; req0_addr = 20'h02000; req0_we = 1'b0;
        req1_valid = 1'b1; req1_addr = 20'h0C000; req1_we = 1'b0;
        prdata = 32'hA5A50001;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k % 3 == 0) begin
                check("t3_grant_port0", req0_ready, ((k / 3) % 2) == 0);
                check("t3_grant_port1", req1_ready, ((k / 3) % 2) == 1);
            end
            step();
        end

        // Unmapped slot 0 on port 0, then slot 7 on port 1
        req1_valid = 1'b0; req0_addr = 20'h00000;
        @(negedge clk); check("t4_ready0", req0_ready, 1'b1); check("t4_no_psel", psel, 1'b0);
        step(); req0_valid = 1'b0;
        @(negedge clk);
        check("t4_psel_never", psel, 1'b0);
        check("t4_rsp0_valid", rsp0_valid, 1'b1);
        check("t4_rsp0_err", rsp0_err, 1'b1);
        check("t4_rsp0_rdata", rsp0_rdata, 32'h0);
        step();
        req1_valid = 1'b1; req1_addr = 20'h0E000;
        @(negedge clk); check("t4_ready1", req1_ready, 1'b1);
        step(); req1_valid = 1'b0;
        @(negedge clk);
        check("t4_slot7_rsp1_valid", rsp1_valid, 1'b1);
        check("t4_slot7_rsp1_err", rsp1_err, 1'b1);
        check("t4_slot7_psel", psel, 1'b0);
        step();

        // PREADY timeout after TIMEOUT access cycles
        req1_valid = 1'b1; req1_addr = 20'h04000; req1_we = 1'b0; pready = 1'b0;
        @(negedge clk); check("t5_ready1", req1_ready, 1'b1);
        step(); req1_valid = 1'b0;
        step();
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk); check("t5_access_penable", penable, 1'b1);
            step();
        end
        @(negedge clk);
        check("t5_psel_dropped", psel, 1'b0);
        check("t5_penable_dropped", penable, 1'b0);
        check("t5_rsp1_valid", rsp1_valid, 1'b1);
        check("t5_rsp1_err", rsp1_err, 1'b1);
        check("t5_rsp1_rdata", rsp1_rdata, 32'h0);
        step(); pready = 1'b1;

        // Reset during ACCESS, then a tie must go to port 0
        req0_valid = 1'b1; req0_addr = 20'h0A000; req0_we = 1'b1; req0_wdata = 32'h11223344;
        pready = 1'b0;
        @(negedge clk); check("t6_ready0", req0_ready, 1'b1);
        step(); req0_valid = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk); check("t6_in_access", penable, 1'b1);
        step(); rst = 1'b0; pready = 1'b1;
        @(negedge clk);
        check("t6_psel_after_rst", psel, 1'b0);
        check("t6_penable_after_rst", penable, 1'b0);
        check("t6_no_rsp0", rsp0_valid, 1'b0);
        step();
        repeat (2) step();
        req0_valid = 1'b1; req0_addr = 20'h02000; req0_we = 1'b0;
        req1_valid = 1'b1; req1_addr = 20'h0C000; req1_we = 1'b0;
        @(negedge clk);
        check("t6_tie_port0", req0_ready, 1'b1);
        check("t6_tie_not_port1", req1_ready, 1'b0);
        step(); req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
